// File: rtl/inst_buffer.sv
// -----------------------------------------------------------------------------
// inst_buffer
//   Dual-slot instruction queue between fetch and decode. Up to two fetched
//   instructions enter per cycle. Valid slots are compacted in program order.
//   The two oldest entries are presented to the two decoder slots. A flush
//   discards all contents.
//
// Ports
//   clk, rst          : core clock; synchronous active-high reset
//   flush             : synchronous discard of all entries (wins over push/pop)
//   fetch_valid[1:0]  : per-slot valid from fetch (00/01/10/11 all legal)
//   fetch_pc/inst/excp/cause{0,1} : fetch slot payloads
//   fetch_ready       : buffer has room for two entries (registered count only)
//   dec_valid[1:0]    : bit0 head valid, bit1 head+1 valid
//   dec_pc/inst/excp/cause{0,1}   : head / head+1 payloads
//   dec_consume[1:0]  : decode accepts slots (00, 01, 11; 10 acts as 00)
//   count             : current occupancy
// -----------------------------------------------------------------------------
module inst_buffer #(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       fetch_valid,
    input  logic [31:0]      fetch_pc0,
    input  logic [31:0]      fetch_pc1,
    input  logic [31:0]      fetch_inst0,
    input  logic [31:0]      fetch_inst1,
    input  logic             fetch_excp0,
    input  logic             fetch_excp1,
    input  logic [6:0]       fetch_cause0,
    input  logic [6:0]       fetch_cause1,
    output logic             fetch_ready,
    output logic [1:0]       dec_valid,
    output logic [31:0]      dec_pc0,
    output logic [31:0]      dec_pc1,
    output logic [31:0]      dec_inst0,
    output logic [31:0]      dec_inst1,
    output logic             dec_excp0,
    output logic             dec_excp1,
    output logic [6:0]       dec_cause0,
    output logic [6:0]       dec_cause1,
    input  logic [1:0]       dec_consume,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      inst_q  [DEPTH];
    logic             excp_q  [DEPTH];
    logic [6:0]       cause_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [1:0]       push_n_s;
    logic [1:0]       push_eff_s;
    logic [1:0]       pop_req_s;
    logic [1:0]       avail_s;
    logic [1:0]       pop_n_s;
    logic [PTR_W-1:0] wr_idx1_s;
    logic [PTR_W-1:0] rd_idx1_s;

    // Room for a full dual push is judged on registered occupancy only, so a
    // same-cycle decode pop never opens the gate (keeps fetch_ready timing-clean).
    assign fetch_ready = ((DEPTH_C - count_q) >= (PTR_W+1)'(2));

    // Push/pop amounts and next-state pointers/occupancy.
    always_comb begin
        push_n_s   = {1'b0, fetch_valid[0]} + {1'b0, fetch_valid[1]};
        push_eff_s = 2'd0;
        pop_req_s  = 2'd0;
        avail_s    = 2'd0;
        pop_n_s    = 2'd0;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (fetch_ready) begin
            push_eff_s = push_n_s;
        end else begin
            push_eff_s = 2'd0;
        end

        // Pattern 10 would leave a hole ahead of the head; treat it as no pop.
        case (dec_consume)
            2'b11:   pop_req_s = 2'd2;
            2'b01:   pop_req_s = 2'd1;
            default: pop_req_s = 2'd0;
        endcase

        // Consuming a slot that is not valid is ignored (no underflow).
        if (count_q >= (PTR_W+1)'(2)) begin
            avail_s = 2'd2;
        end else begin
            avail_s = count_q[1:0];
        end

        if (pop_req_s < avail_s) begin
            pop_n_s = pop_req_s;
        end else begin
            pop_n_s = avail_s;
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop_n_s);
            tail_d  = tail_q + PTR_W'(push_eff_s);
            count_d = count_q + (PTR_W+1)'(push_eff_s) - (PTR_W+1)'(pop_n_s);
        end
    end

    // Slot1 lands right behind slot0, or at the tail itself when slot0 is empty.
    assign wr_idx1_s = tail_q + PTR_W'(fetch_valid[0]);
    assign rd_idx1_s = head_q + PTR_W'(1);

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; cleared on reset so idle decode fields read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= 32'd0;
                inst_q[i]  <= 32'd0;
                excp_q[i]  <= 1'b0;
                cause_q[i] <= 7'd0;
            end
        end else if (!flush && fetch_ready) begin
            if (fetch_valid[0]) begin
                pc_q[tail_q]    <= fetch_pc0;
                inst_q[tail_q]  <= fetch_inst0;
                excp_q[tail_q]  <= fetch_excp0;
                cause_q[tail_q] <= fetch_cause0;
            end
            if (fetch_valid[1]) begin
                pc_q[wr_idx1_s]    <= fetch_pc1;
                inst_q[wr_idx1_s]  <= fetch_inst1;
                excp_q[wr_idx1_s]  <= fetch_excp1;
                cause_q[wr_idx1_s] <= fetch_cause1;
            end
        end
    end

    assign dec_valid  = (count_q >= (PTR_W+1)'(2)) ? 2'b11 :
                        ((count_q == (PTR_W+1)'(1)) ? 2'b01 : 2'b00);
    assign dec_pc0    = pc_q[head_q];
    assign dec_pc1    = pc_q[rd_idx1_s];
    assign dec_inst0  = inst_q[head_q];
    assign dec_inst1  = inst_q[rd_idx1_s];
    assign dec_excp0  = excp_q[head_q];
    assign dec_excp1  = excp_q[rd_idx1_s];
    assign dec_cause0 = cause_q[head_q];
    assign dec_cause1 = cause_q[rd_idx1_s];
    assign count      = count_q;

endmodule

// File: tb/tb_inst_buffer.sv
// -----------------------------------------------------------------------------
// tb_inst_buffer
//   Randomized self-checking bench for inst_buffer. The reference is a plain
//   FIFO queue of expected entries. The driver pushes entries it expects to be
//   accepted. The monitor checks occupancy/valid/ready every cycle. It also
//   compares and pops each entry as decode consumes it.
// -----------------------------------------------------------------------------
module tb_inst_buffer;

    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
        logic [6:0]  cause;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  fetch_valid;
    logic [31:0] fetch_pc0, fetch_pc1, fetch_inst0, fetch_inst1;
    logic        fetch_excp0, fetch_excp1;
    logic [6:0]  fetch_cause0, fetch_cause1;
    logic        fetch_ready;
    logic [1:0]  dec_valid;
    logic [31:0] dec_pc0, dec_pc1, dec_inst0, dec_inst1;
    logic        dec_excp0, dec_excp1;
    logic [6:0]  dec_cause0, dec_cause1;
    logic [1:0]  dec_consume;
    logic [4:0]  count;

    ent_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    bit   mon_en    = 1'b0;

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fetch_valid(fetch_valid),
        .fetch_pc0(fetch_pc0), .fetch_pc1(fetch_pc1),
        .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1),
        .fetch_excp0(fetch_excp0), .fetch_excp1(fetch_excp1),
        .fetch_cause0(fetch_cause0), .fetch_cause1(fetch_cause1),
        .fetch_ready(fetch_ready),
        .dec_valid(dec_valid),
        .dec_pc0(dec_pc0), .dec_pc1(dec_pc1),
        .dec_inst0(dec_inst0), .dec_inst1(dec_inst1),
        .dec_excp0(dec_excp0), .dec_excp1(dec_excp1),
        .dec_cause0(dec_cause0), .dec_cause1(dec_cause1),
        .dec_consume(dec_consume),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Monitor: state checks at the falling edge, then compare-and-pop of the
    // slots decode consumes once the driver has set this cycle's inputs.
    always @(negedge clk) begin
        if (mon_en) begin
            int sz;
            int n;
            ent_t e;
            sz = exp_q.size();
            check("count", 32'(count), 32'(sz));
            check("fetch_ready", 32'(fetch_ready), (sz <= DEPTH - 2) ? 32'd1 : 32'd0);
            check("dec_valid", 32'(dec_valid), (sz >= 2) ? 32'd3 : ((sz == 1) ? 32'd1 : 32'd0));
            #2;
            if (flush) begin
                exp_q.delete();
            end else begin
                n = (dec_consume == 2'b11) ? 2 : ((dec_consume == 2'b01) ? 1 : 0);
                if (n > exp_q.size()) n = exp_q.size();
                for (int i = 0; i < n; i++) begin
                    e = exp_q.pop_front();
                    if (i == 0) begin
                        check("dec_pc0", dec_pc0, e.pc);
                        check("dec_inst0", dec_inst0, e.inst);
                        check("dec_excp0", 32'(dec_excp0), 32'(e.excp));
                        check("dec_cause0", 32'(dec_cause0), 32'(e.cause));
                    end else begin
                        check("dec_pc1", dec_pc1, e.pc);
                        check("dec_inst1", dec_inst1, e.inst);
                        check("dec_excp1", 32'(dec_excp1), 32'(e.excp));
                        check("dec_cause1", 32'(dec_cause1), 32'(e.cause));
                    end
                end
            end
        end
    end

    // Driver: reset, directed reset checks, then phased random traffic.
    initial begin
        logic [31:0] pc_ctr;
        bit          acc;
        int          phase;
        int          r;
        ent_t        e0, e1;

        rst = 1'b1; flush = 1'b0; fetch_valid = 2'b00; dec_consume = 2'b00;
        fetch_pc0 = 32'd0; fetch_pc1 = 32'd0; fetch_inst0 = 32'd0; fetch_inst1 = 32'd0;
        fetch_excp0 = 1'b0; fetch_excp1 = 1'b0; fetch_cause0 = 7'd0; fetch_cause1 = 7'd0;
        pc_ctr = 32'h1c00_0000;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_dec_pc0", dec_pc0, 32'd0);
        check("rst_dec_inst1", dec_inst1, 32'd0);
        mon_en = 1'b1;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            #1;
            // 0: fill (no decode)  1: 2-in/2-out streaming (wrap)
            // 2: fully random with flushes and illegal consume  3: drain
            phase = (cyc / 100) % 4;
            r = $urandom_range(0, 99);
            case (phase)
                0: begin
                    flush = 1'b0;
                    fetch_valid = 2'($urandom_range(1, 3));
                    dec_consume = (r < 85) ? 2'b00 : 2'b10;
                end
                1: begin
                    flush = 1'b0;
                    fetch_valid = 2'b11;
                    dec_consume = 2'b11;
                end
                2: begin
                    flush = (r < 4);
                    fetch_valid = 2'($urandom_range(0, 3));
                    dec_consume = 2'($urandom_range(0, 3));
                end
                default: begin
                    flush = 1'b0;
                    fetch_valid = (r < 30) ? 2'($urandom_range(0, 3)) : 2'b00;
                    dec_consume = (r < 60) ? 2'b11 : 2'b01;
                end
            endcase

            acc = !flush && (exp_q.size() <= DEPTH - 2);
            fetch_pc0    = pc_ctr;
            fetch_pc1    = pc_ctr + (fetch_valid[0] ? 32'd4 : 32'd0);
            fetch_inst0  = $urandom;
            fetch_inst1  = $urandom;
            fetch_excp0  = 1'($urandom_range(0, 1));
            fetch_excp1  = 1'($urandom_range(0, 1));
            fetch_cause0 = 7'($urandom_range(0, 127));
            fetch_cause1 = 7'($urandom_range(0, 127));
            e0 = '{fetch_pc0, fetch_inst0, fetch_excp0, fetch_cause0};
            e1 = '{fetch_pc1, fetch_inst1, fetch_excp1, fetch_cause1};
            if (acc) begin
                pc_ctr = pc_ctr + 32'd4 * 32'(int'(fetch_valid[0]) + int'(fetch_valid[1]));
            end else begin
                pc_ctr = pc_ctr;
            end

            #2;  // monitor has popped this cycle's consumed slots by now
            if (acc) begin
                if (fetch_valid[0]) exp_q.push_back(e0);
                if (fetch_valid[1]) exp_q.push_back(e1);
            end
        end

        @(negedge clk);
        #4;
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/inst_buffer.md
# inst_buffer

Dual-slot instruction queue between the fetch stage and the decode stage. Accepts up to two fetched instructions per cycle (PC, instruction word, fetch-side exception tag) and presents the two oldest entries, in program order, to the two decoder slots. Absorbs fetch/decode rate mismatch and discards all contents on a pipeline flush (branch mispredict, exception, ertn).

## Interface

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous discard of all entries
- fetch_valid  input  2  per-slot valid from fetch; any of 00/01/10/11 legal
- fetch_pc0, fetch_pc1  input  32 each  slot PCs
- fetch_inst0, fetch_inst1  input  32 each  slot instruction words
- fetch_excp0, fetch_excp1  input  1 each  fetch-side exception flag
- fetch_cause0, fetch_cause1  input  7 each  exception cause code
- fetch_ready  output  1  buffer can accept two instructions this cycle
- dec_valid  output  2  bit0: entry at head valid; bit1: head+1 valid
- dec_pc0, dec_pc1  output  32 each  head / head+1 PC
- dec_inst0, dec_inst1  output  32 each  head / head+1 instruction word
- dec_excp0, dec_excp1  output  1 each  exception flag
- dec_cause0, dec_cause1  output  7 each  exception cause
- dec_consume  input  2  decode accepts slots; legal patterns 00, 01, 11
- count  output  PTR_W+1  current occupancy (debug/perf)

## Operation

- Storage: circular array of DEPTH entries {pc, inst, excp, cause}; head (read) and tail (write) pointers PTR_W bits, wrap modulo DEPTH; occupancy counter PTR_W+1 bits.
- Push: only when fetch_ready=1. Valid slots compacted in order: slot0 (if valid) written at tail, slot1 (if valid) at tail or tail+1. push_n = popcount(fetch_valid). fetch_valid=10 writes slot1 at tail, push_n=1. fetch_valid ignored when fetch_ready=0 (fetch must hold).
- fetch_ready = (DEPTH − count) ≥ 2, from registered count only; no dependence on same-cycle dec_consume.
- Pop: pop_n = number of consumed slots that are valid: dec_consume & dec_valid, pattern 11 counts 2, 01 counts 1. dec_consume=10 is illegal: treated as 00. Consuming an invalid slot is ignored.
- dec_valid = 11 if count ≥ 2, 01 if count = 1, 00 if 0. Output fields driven from entries at head and head+1 (wrapped); fields of invalid slots are don't-care but must not be X after reset (storage reset to 0).
- Same-cycle push and pop: count_next = count + push_n − pop_n; head += pop_n, tail += push_n.
- Flush: head, tail, count ← 0; all push/pop in that cycle discarded. Flush has priority over everything except rst.
- rst: identical to flush plus storage cleared to 0.
- Occupancy never exceeds DEPTH; never underflows (pop clamped by dec_valid).

## Timing

- Reset values: fetch_ready=1, dec_valid=00, count=0, all dec_* data outputs 0.
- Write-to-read latency 1 cycle: instruction pushed in cycle N appears on dec_* in cycle N+1 at earliest (no bypass from fetch to decode).
- dec_* outputs are a function of registered state only; dec_consume affects state at next edge.
- Flush asserted in cycle N: in cycle N+1 dec_valid=00, fetch_ready=1; a push presented in N+1 is accepted.
- Throughput: sustained 2 in / 2 out per cycle when neither side stalls.
- Full boundary: count = DEPTH−1 → fetch_ready=0 even if decode pops 2 the same cycle; reasserts next cycle.
- Pointer wrap: entry at index DEPTH−1 followed by index 0 with no bubble; dec slot1 reads index 0 when head = DEPTH−1.

## Test plan

- Reset then idle: rst high 2 cycles, low → fetch_ready=1, dec_valid=00, count=0, dec_pc0=0.
- Order/compaction: push {pc 0x1c000000, 0x1c000004} valid 11, then valid 10 with pc1=0x1c00000c → next cycles dec_pc0/1 = 0x1c000000/0x1c000004, after consume 11 dec_pc0=0x1c00000c, dec_valid=01.
- Fill to full with dec_consume=00, DEPTH=16: after 8 dual pushes count=16, fetch_ready=0, fetch_valid ignored; at count=15 fetch_ready=0.
- Wrap: steady push 11 / consume 11 for 20 cycles with incrementing PCs step 4 → dec_pc sequence contiguous, no gap or duplicate across index 15→0.
- Flush mid-stream: count=6, assert flush with fetch_valid=11 and dec_consume=11 → next cycle count=0, dec_valid=00, fetch_ready=1; those pushes not present.
- Illegal consume: count=3, dec_consume=10 → count stays 3, head unchanged; dec_consume=11 with count=1 → count 0.
